// File: rtl/router_dest_port.sv
// Destination-side output port: buffers {lfd, byte} entries, delivers them over vld_out/read_enb,
// tracks packet framing for pkt_done, and self-flushes when the destination stalls too long.
module router_dest_port #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enb,
    input  logic                  lfd_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  vld_out,
    output logic                  full,
    output logic                  empty,
    output logic                  soft_reset,
    output logic                  pkt_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = DATA_WIDTH - 1;

    typedef enum logic {RD_IDLE, RD_BODY} rd_state_t;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [TW-1:0]         timer;
    rd_state_t             state, state_nxt;
    logic [RW-1:0]         remaining, rem_nxt;
    logic                  done_nxt;

    logic                  stall, fire, do_read, do_write;
    logic [DATA_WIDTH:0]   rd_entry;
    logic [DATA_WIDTH-3:0] hdr_len;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign vld_out  = !empty;

    // Flush fires on the edge that closes the TIMEOUT-th consecutive stalled cycle.
    assign stall    = vld_out && !read_enb;
    assign fire     = stall && (timer == TW'(TIMEOUT - 1));
    assign do_read  = read_enb && !empty;
    assign do_write = write_enb && !full && !fire;

    assign rd_entry = mem[rd_ptr];
    assign hdr_len  = rd_entry[DATA_WIDTH-1:2];

    always_ff @(posedge clock) begin
        if (do_write) mem[wr_ptr] <= {lfd_in, data_in};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            timer      <= '0;
            data_out   <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= fire;
            if (fire) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                timer    <= '0;
                data_out <= '0;
            end else begin
                if (do_write) wr_ptr <= wr_ptr + 1'b1;
                if (do_read) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    data_out <= rd_entry[DATA_WIDTH-1:0];
                end
                case ({do_write, do_read})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (!stall)                        timer <= '0;
                else if (timer != TW'(TIMEOUT))    timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RD_IDLE;
            remaining <= '0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            pkt_done  <= done_nxt;
        end
    end

    // A header read always (re)starts framing: L payload bytes plus one parity byte remain.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        done_nxt  = 1'b0;
        if (do_read) begin
            if (rd_entry[DATA_WIDTH]) begin
                state_nxt = RD_BODY;
                rem_nxt   = {1'b0, hdr_len} + RW'(1);
            end else if (state == RD_BODY) begin
                rem_nxt = remaining - RW'(1);
                if (remaining == RW'(1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = RD_IDLE;
                end
            end
        end
        if (fire) begin
            state_nxt = RD_IDLE;
            rem_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end
endmodule

// File: tb/tb_router_dest_port.sv
// Randomized bench for router_dest_port against a queue-based packet/timeout reference model.
module tb_router_dest_port;
    localparam int DW = 8, DEPTH = 16, TO = 30;

    logic          clock = 1'b0, reset;
    logic          write_enb, lfd_in, read_enb;
    logic [DW-1:0] data_in, data_out;
    logic          vld_out, full, empty, soft_reset, pkt_done;

    router_dest_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .write_enb(write_enb), .lfd_in(lfd_in),
        .data_in(data_in), .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
        .full(full), .empty(empty), .soft_reset(soft_reset), .pkt_done(pkt_done)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: FIFO as a queue, framing as "bytes left in current packet".
    logic [DW:0]   q[$];
    logic [DW-1:0] m_dout;
    bit            m_pkt, m_soft, in_pkt;
    int            m_left, m_timer;

    task automatic model_clear();
        q.delete();
        m_dout = '0; m_pkt = 0; m_soft = 0; in_pkt = 0; m_left = 0; m_timer = 0;
    endtask

    task automatic check_outputs();
        chk("data_out",   32'(data_out),   32'(m_dout));
        chk("vld_out",    32'(vld_out),    32'(q.size() != 0));
        chk("full",       32'(full),       32'(q.size() == DEPTH));
        chk("empty",      32'(empty),      32'(q.size() == 0));
        chk("soft_reset", 32'(soft_reset), 32'(m_soft));
        chk("pkt_done",   32'(pkt_done),   32'(m_pkt));
    endtask

    task automatic step(input bit we, input bit lfd, input logic [DW-1:0] din, input bit re);
        bit mfull, mempty, stall, fire;
        logic [DW:0] e;
        write_enb = we; lfd_in = lfd; data_in = din; read_enb = re;
        mfull  = (q.size() == DEPTH);
        mempty = (q.size() == 0);
        stall  = !mempty && !re;
        fire   = stall && (m_timer + 1 == TO);
        m_pkt  = 0; m_soft = 0;
        if (fire) begin
            model_clear();
            m_soft = 1;
        end else begin
            if (re && !mempty) begin
                e = q.pop_front();
                m_dout = e[DW-1:0];
                if (e[DW]) begin
                    in_pkt = 1;
                    m_left = int'(e[DW-1:2]) + 1;
                end else if (in_pkt) begin
                    m_left--;
                    if (m_left == 0) begin in_pkt = 0; m_pkt = 1; end
                end
            end
            if (we && !mfull) q.push_back({lfd, din});
            m_timer = stall ? m_timer + 1 : 0;
        end
        @(posedge clock); #1;
        check_outputs();
    endtask

    task automatic rand_step(input int we_pct, input int re_pct);
        bit we, re, lfd;
        logic [DW-1:0] d;
        we  = ($urandom_range(0, 99) < we_pct);
        re  = ($urandom_range(0, 99) < re_pct);
        lfd = ($urandom_range(0, 7) == 0);
        d   = lfd ? DW'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3)) : DW'($urandom);
        step(we, lfd, d, re);
    endtask

    initial begin
        reset = 1'b1; write_enb = 0; lfd_in = 0; data_in = '0; read_enb = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b0;

        // Asynchronous reset with 5 entries stored
        for (int i = 0; i < 5; i++) step(1, 0, DW'(8'h40 + i), 0);
        #3 reset = 1'b1;
        #1;
        chk("rst_vld",   32'(vld_out),    32'd0);
        chk("rst_empty", 32'(empty),      32'd1);
        chk("rst_dout",  32'(data_out),   32'd0);
        chk("rst_pkt",   32'(pkt_done),   32'd0);
        chk("rst_soft",  32'(soft_reset), 32'd0);
        model_clear();
        @(posedge clock); #1;
        reset = 1'b0;
        step(1, 0, 8'h5A, 0);
        step(0, 0, 8'h00, 1);
        chk("rst_first_rd", 32'(data_out), 32'h5A);

        // Framed packet, L=3
        step(1, 1, 8'h0C, 0);
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 0);
        step(1, 0, 8'h3E, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
        chk("pkt_parity", 32'(data_out), 32'h3E);
        chk("pkt_pulse",  32'(pkt_done), 32'd1);
        step(0, 0, 8'h00, 1);

        // Fill past capacity, drain
        for (int i = 0; i < 17; i++) step(1, 0, DW'(i), 0);
        chk("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);
        chk("drain_last", 32'(data_out), 32'h0F);

        // Simultaneous read+write at full and at empty
        for (int i = 0; i < 16; i++) step(1, 0, DW'(8'h80 + i), 0);
        step(1, 0, 8'hEE, 1);
        chk("rw_full", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1);
        step(1, 0, 8'h77, 1);
        chk("rw_empty_dout", 32'(data_out), 32'h8F);

        // Timeout flush and near-miss
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h01, 0);
        step(1, 0, 8'h02, 0);
        for (int i = 0; i < 28; i++) step(0, 0, 8'h00, 0);
        chk("to_early", 32'(soft_reset), 32'd0);
        step(0, 0, 8'h00, 0);
        chk("to_fire",  32'(soft_reset), 32'd1);
        chk("to_empty", 32'(empty),      32'd1);
        step(1, 0, 8'h01, 0);
        step(1, 0, 8'h02, 0);
        for (int i = 0; i < 27; i++) step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 25; i++) step(0, 0, 8'h00, 0);
        chk("to_cleared", 32'(soft_reset), 32'd0);
        step(0, 0, 8'h00, 1);

        // L=0 packet, then header arriving inside a body
        step(1, 1, 8'h00, 0);
        step(1, 0, 8'hA5, 0);
        step(1, 1, 8'h08, 0);
        step(1, 0, 8'h55, 0);
        step(1, 1, 8'h04, 0);
        step(1, 0, 8'h66, 0);
        step(1, 0, 8'h67, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1);

        // Random traffic: busy phase, then a stall-heavy phase that provokes flushes
        for (int i = 0; i < 1500; i++) rand_step(60, 50);
        for (int i = 0; i < 600; i++)  rand_step(25, 5);
        for (int i = 0; i < 500; i++)  rand_step(50, 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
